pot_accumulator: RTL

Sequencer that computes one MSDAP output sample by driving the shared 40-bit add/subtract unit through a power-of-two-coefficient convolution. It walks 16 coefficient groups, reading group sizes (r_j), coefficient words and delayed input samples from external memories. Each coefficient issues one add or subtract of the aligned sample onto a running accumulator, and an arithmetic right shift follows each group. It sits between the coefficient/data memories and the adder, and hands the finished 40-bit result to the output serializer.

---
 rtl/pot_accumulator_pkg.sv | 34 +++
 rtl/pot_accumulator_if.sv | 15 +
 rtl/pot_accumulator.sv | 105 ++++++++++
 3 files changed

// File: rtl/pot_accumulator_pkg.sv
// Shared types and constants for the power-of-two-coefficient convolution sequencer.
// Also provides the helpers that align a sample onto the accumulator and do the group shift.
package pot_accumulator_pkg;

  localparam int NUM_GROUPS = 16;
  localparam int ACC_W      = 40;
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int CO_AW      = 9;
  localparam int X_AW       = 8;
  localparam int RJ_W       = 8;
  localparam int GRP_W      = 4;
  localparam int SIGN_BIT   = 8;
  localparam int FRAC_W     = 16;
  localparam int GUARD_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_R,
    S_ACCUM,
    S_SHIFT,
    S_DONE
  } state_t;

  // Sample lands at the 2^0 position with 16 fractional zero bits and 8 sign-guard bits.
  function automatic logic signed [ACC_W-1:0] align_sample(input logic signed [DATA_W-1:0] x);
    return {{GUARD_W{x[DATA_W-1]}}, x, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic signed [ACC_W-1:0] asr1(input logic signed [ACC_W-1:0] v);
    return v >>> 1;
  endfunction

endpackage

// File: rtl/pot_accumulator_if.sv
// Bus between the sequencer and the shared 40-bit add/subtract unit.
// The sequencer is the master; the adder answers combinationally on add_sum.
interface pot_accumulator_if;
  import pot_accumulator_pkg::*;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic             add_sub;
  logic             add_en;
  logic [ACC_W-1:0] add_sum;

  modport master (output add_a, output add_b, output add_sub, output add_en, input add_sum);
  modport slave  (input add_a, input add_b, input add_sub, input add_en, output add_sum);

endinterface

// File: rtl/pot_accumulator.sv
// Walks 16 coefficient groups, issuing one add/subtract per coefficient through the external
// adder and halving the accumulator after each group; the last shift yields one output sample.
module pot_accumulator
  import pot_accumulator_pkg::*;
(
  input  logic                 Sclk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [X_AW-1:0]      n_idx,
  output logic [GRP_W-1:0]     rj_addr,
  input  logic [RJ_W-1:0]      rj_data,
  output logic [CO_AW-1:0]     co_addr,
  input  logic [COEF_W-1:0]    co_data,
  output logic [X_AW-1:0]      x_addr,
  input  logic [DATA_W-1:0]    x_data,
  pot_accumulator_if.master    add,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     y
);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_shifted;
  logic [RJ_W-1:0]          cnt;
  logic [GRP_W-1:0]         j;
  logic [CO_AW-1:0]         co_ptr;
  logic [X_AW-1:0]          n_q;
  logic                     last_group;

  // Only the sign and delay fields of a coefficient word carry meaning.
  logic unused_co_bits;
  assign unused_co_bits = ^co_data[COEF_W-1:SIGN_BIT+1];

  assign last_group  = (j == GRP_W'(NUM_GROUPS - 1));
  assign acc_shifted = asr1(acc);

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_R;
      S_LOAD_R: state_nxt = (rj_data == '0) ? S_SHIFT : S_ACCUM;
      S_ACCUM:  if (cnt == RJ_W'(1)) state_nxt = S_SHIFT;
      S_SHIFT:  state_nxt = last_group ? S_DONE : S_LOAD_R;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    add.add_en  = 1'b0;
    add.add_sub = 1'b0;
    x_addr      = '0;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    if (state == S_ACCUM) begin
      add.add_en  = 1'b1;
      add.add_sub = co_data[SIGN_BIT];
      x_addr      = n_q - co_data[X_AW-1:0];
    end
  end

  assign add.add_a = align_sample(signed'(x_data));
  assign add.add_b = acc;
  assign rj_addr   = j;
  assign co_addr   = co_ptr;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc    <= '0;
      cnt    <= '0;
      j      <= '0;
      co_ptr <= '0;
      n_q    <= '0;
      y      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          n_q    <= n_idx;
          acc    <= '0;
          j      <= '0;
          co_ptr <= '0;
        end
        S_LOAD_R: cnt <= rj_data;
        S_ACCUM: begin
          acc    <= signed'(add.add_sum);
          co_ptr <= co_ptr + CO_AW'(1);
          cnt    <= cnt - RJ_W'(1);
        end
        S_SHIFT: begin
          acc <= acc_shifted;
          if (last_group) y <= acc_shifted;
          else            j <= j + GRP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
